// File: rtl/red_pitaya_fads_pkg.sv
// Shared constants for the FADS sort scheduler: register map, FSM encoding, reset defaults.
// Pure declarations; no latency or backpressure of its own.
`timescale 1ns/1ps
package red_pitaya_fads_pkg;

    localparam logic [19:0] REG_CTRL     = 20'h00;
    localparam logic [19:0] REG_DELAY    = 20'h04;
    localparam logic [19:0] REG_DURATION = 20'h08;
    localparam logic [19:0] REG_GAP      = 20'h0C;
    localparam logic [19:0] REG_STATUS   = 20'h10;
    localparam logic [19:0] REG_ACCEPTED = 20'h14;
    localparam logic [19:0] REG_DROPPED  = 20'h18;
    localparam logic [19:0] REG_FIRED    = 20'h1C;
    localparam logic [19:0] REG_LATE     = 20'h20;
    localparam logic [19:0] REG_CNT_CLR  = 20'h24;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    localparam logic [31:0] DELAY_RST    = 32'd31250;
    localparam logic [31:0] DURATION_RST = 32'd125000;
    localparam logic [31:0] GAP_RST      = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } sort_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/red_pitaya_sort_fifo.sv
// Pending-event FIFO of due timestamps; head/count/full reflect the registered state.
// One-cycle push-to-head latency; pushes while full are ignored, flush beats push and pop.
`timescale 1ns/1ps
module red_pitaya_sort_fifo #(
    parameter int TW         = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [TW-1:0]         din_i,
    output logic [TW-1:0]         head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [TW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/red_pitaya_sort_scheduler.sv
// Queues classifier requests with their due time and emits one sort pulse per due entry.
// Pulse rises sort_delay+2 cycles after the request; no backpressure, requests to a full queue are dropped and counted.
`timescale 1ns/1ps
module red_pitaya_sort_scheduler
    import red_pitaya_fads_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int TW         = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        sort_req_i,
    output logic        sort_trig_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);
    localparam int CW = DEPTH_LOG2 + 1;

    logic [19:0]   reg_addr;
    logic [TW-1:0] wr_val;
    logic          flush, cnt_clr, unused_bus;

    assign reg_addr   = sys_addr[19:0];
    assign wr_val     = TW'(sys_wdata);
    assign flush      = sys_wen && (reg_addr == REG_CTRL) && sys_wdata[CTRL_FLUSH_BIT];
    assign cnt_clr    = sys_wen && (reg_addr == REG_CNT_CLR);
    assign unused_bus = ^{sys_sel, sys_addr[31:20]};

    logic          enable_q, enable_d;
    logic [TW-1:0] delay_q, delay_d, dur_q, dur_d, gap_q, gap_d;

    always_comb begin
        enable_d = enable_q;
        delay_d  = delay_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        if (sys_wen) begin
            case (reg_addr)
                REG_CTRL:     enable_d = sys_wdata[CTRL_ENABLE_BIT];
                REG_DELAY:    delay_d  = {1'b0, wr_val[TW-2:0]};
                REG_DURATION: dur_d    = wr_val;
                REG_GAP:      gap_d    = wr_val;
                default:      ;
            endcase
        end
    end

    logic [TW-1:0] ts_q, ts_d, head, ts_head_diff;
    logic [CW-1:0] fill;
    logic          full, req_ok, push, drop, pop, head_due;

    assign ts_d   = ts_q + TW'(1);
    assign req_ok = sort_req_i && enable_q && !flush;
    assign push   = req_ok && !full;
    assign drop   = req_ok && full;

    // Entries carry the timestamp that is current once they become visible at the head.
    red_pitaya_sort_fifo #(
        .TW         (TW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (adc_clk_i),
        .rst_i   (adc_rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (ts_d + delay_q),
        .head_o  (head),
        .count_o (fill),
        .full_o  (full)
    );

    assign ts_head_diff = ts_q - head;
    assign head_due     = (fill != '0) && !ts_head_diff[TW-1];

    sort_state_e   state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          fire, fire_late, trig_q, trig_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        fire      = 1'b0;
        fire_late = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_due) begin
                    pop = 1'b1;
                    if (dur_q != '0) begin
                        state_d   = ST_PULSE;
                        cnt_d     = dur_q;
                        fire      = 1'b1;
                        fire_late = (ts_q != head);
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q <= TW'(1)) begin
                    state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
                    cnt_d   = gap_q;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q <= TW'(1)) state_d = ST_IDLE;
                else                 cnt_d   = cnt_q - TW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pop     = 1'b0;
            fire    = 1'b0;
        end
    end

    // Output register trails the state by one cycle, giving the fixed delay+2 latency.
    assign trig_d = (state_q == ST_PULSE) && !flush;
    assign busy_o = (fill != '0) || (state_q != ST_IDLE);

    logic [31:0] accepted_q, accepted_d, dropped_q, dropped_d;
    logic [31:0] fired_q, fired_d, late_q, late_d;

    always_comb begin
        accepted_d = accepted_q;
        dropped_d  = dropped_q;
        fired_d    = fired_q;
        late_d     = late_q;
        if (cnt_clr) begin
            accepted_d = '0;
            dropped_d  = '0;
            fired_d    = '0;
            late_d     = '0;
        end else begin
            if (push)              accepted_d = sat_inc(accepted_q);
            if (drop)              dropped_d  = sat_inc(dropped_q);
            if (fire)              fired_d    = sat_inc(fired_q);
            if (fire && fire_late) late_d     = sat_inc(late_q);
        end
    end

    logic [31:0] status, rd_mux, rdata_q, rdata_d;
    logic        ack_q, ack_d;

    assign status = {20'd0, state_q, busy_o, full, 8'(fill)};

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_CTRL:     rd_mux = {31'd0, enable_q};
            REG_DELAY:    rd_mux = 32'(delay_q);
            REG_DURATION: rd_mux = 32'(dur_q);
            REG_GAP:      rd_mux = 32'(gap_q);
            REG_STATUS:   rd_mux = status;
            REG_ACCEPTED: rd_mux = accepted_q;
            REG_DROPPED:  rd_mux = dropped_q;
            REG_FIRED:    rd_mux = fired_q;
            REG_LATE:     rd_mux = late_q;
            default:      rd_mux = '0;
        endcase
    end

    assign ack_d   = sys_wen | sys_ren;
    assign rdata_d = sys_ren ? rd_mux : '0;

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            enable_q   <= 1'b1;
            delay_q    <= TW'(DELAY_RST);
            dur_q      <= TW'(DURATION_RST);
            gap_q      <= TW'(GAP_RST);
            ts_q       <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            trig_q     <= 1'b0;
            accepted_q <= '0;
            dropped_q  <= '0;
            fired_q    <= '0;
            late_q     <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            delay_q    <= delay_d;
            dur_q      <= dur_d;
            gap_q      <= gap_d;
            ts_q       <= ts_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trig_q     <= trig_d;
            accepted_q <= accepted_d;
            dropped_q  <= dropped_d;
            fired_q    <= fired_d;
            late_q     <= late_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    assign sort_trig_o = trig_q;
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Bench for the sort scheduler: directed scenarios plus randomized request trains vs a schedule model.
`timescale 1ns/1ps
module tb_red_pitaya_sort_scheduler;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_CTRL = 32'h00, A_DELAY = 32'h04, A_DUR = 32'h08, A_GAP = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10, A_ACC = 32'h14, A_DROP = 32'h18;
    localparam logic [31:0] A_FIRED = 32'h1C, A_LATE = 32'h20, A_CLR = 32'h24;

    logic        clk = 1'b0, rst = 1'b1, sort_req = 1'b0;
    logic        sort_trig, busy;
    logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
    logic [3:0]  sys_sel = 4'hF;
    logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;

    always #4 clk = ~clk;

    red_pitaya_sort_scheduler #(.DEPTH_LOG2(3), .TW(32)) dut (
        .adc_clk_i   (clk),
        .adc_rst_i   (rst),
        .sort_req_i  (sort_req),
        .sort_trig_o (sort_trig),
        .busy_o      (busy),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    int n_chk = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulses: edge index of the first high sample and length in cycles.
    int   obs_start[$], obs_len[$];
    logic trig_prev = 1'b0;
    int   cur_start = 0;
    always @(negedge clk) begin
        if (sort_trig && !trig_prev) cur_start = cyc;
        if (!sort_trig && trig_prev) begin
            obs_start.push_back(cur_start);
            obs_len.push_back(cyc - cur_start);
        end
        trig_prev = sort_trig;
    end

    // Schedule model in edge indices: entry k due at k+delay+1 pop, pulse one edge later.
    bit m_en = 1'b1;
    int m_delay, m_dur, m_gap, free_pop;
    int q_push[$], q_pop[$], exp_start[$], exp_len[$];
    int m_acc, m_drop, m_fired, m_late;
    int last_k;

    function automatic void model_req(input int k);
        int occ, p;
        occ = 0;
        if (!m_en) return;
        foreach (q_push[i]) if (q_push[i] < k && q_pop[i] >= k) occ++;
        if (occ >= DEPTH) begin
            m_drop++;
            return;
        end
        p = k + m_delay + 1;
        if (p < free_pop) p = free_pop;
        q_push.push_back(k);
        q_pop.push_back(p);
        m_acc++;
        if (m_dur == 0) begin
            free_pop = p + 1;
        end else begin
            m_fired++;
            if (p > k + m_delay + 1) m_late++;
            exp_start.push_back(p + 1);
            exp_len.push_back(m_dur);
            free_pop = p + m_dur + m_gap + 1;
        end
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_req(input bit r);
        @(negedge clk);
        sort_req = r;
        if (r) begin
            last_k = cyc + 1;
            model_req(cyc + 1);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        sort_req  = 1'b0;
        sys_addr  = addr;
        sys_wdata = data;
        sys_wen   = 1'b1;
        @(negedge clk);
        sys_wen   = 1'b0;
        if (addr == A_CTRL) m_en = data[0];
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        sort_req = 1'b0;
        sys_addr = addr;
        sys_ren  = 1'b1;
        @(negedge clk);
        sys_ren  = 1'b0;
        chk_eq("read_ack", sys_ack, 1);
        data = sys_rdata;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || sort_trig) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_timeout", n >= budget, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_trig(input int budget);
        int n;
        n = 0;
        while (!sort_trig && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("trig_timeout", n < budget, 1);
    endtask

    task automatic begin_scn(input int dly, input int dur, input int gap);
        bus_write(A_DELAY, dly);
        bus_write(A_DUR, dur);
        bus_write(A_GAP, gap);
        bus_write(A_CLR, 32'd0);
        m_delay = dly; m_dur = dur; m_gap = gap; free_pop = 0;
        m_acc = 0; m_drop = 0; m_fired = 0; m_late = 0;
        q_push.delete(); q_pop.delete(); exp_start.delete(); exp_len.delete();
        obs_start.delete(); obs_len.delete();
    endtask

    task automatic check_sched(input string tag);
        logic [31:0] d;
        chk_eq({tag, "_npulse"}, obs_start.size(), exp_start.size());
        for (int i = 0; i < exp_start.size() && i < obs_start.size(); i++) begin
            chk_eq($sformatf("%s_start%0d", tag, i), obs_start[i], exp_start[i]);
            chk_eq($sformatf("%s_len%0d", tag, i), obs_len[i], exp_len[i]);
        end
        bus_read(A_ACC, d);   chk_eq({tag, "_accepted"}, d, m_acc);
        bus_read(A_DROP, d);  chk_eq({tag, "_dropped"}, d, m_drop);
        bus_read(A_FIRED, d); chk_eq({tag, "_fired"}, d, m_fired);
        bus_read(A_LATE, d);  chk_eq({tag, "_late"}, d, m_late);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_trig", sort_trig, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_ack", sys_ack, 0);
        chk_eq("rst_rdata", sys_rdata, 0);
        chk_eq("rst_err", sys_err, 0);
        rst = 1'b0;

        bus_read(A_CTRL, rd);   chk_eq("def_ctrl", rd, 32'd1);
        bus_read(A_DELAY, rd);  chk_eq("def_delay", rd, 32'd31250);
        bus_read(A_DUR, rd);    chk_eq("def_dur", rd, 32'd125000);
        bus_read(A_GAP, rd);    chk_eq("def_gap", rd, 32'd0);
        bus_read(A_STATUS, rd); chk_eq("def_status", rd, 32'd0);
        bus_read(A_ACC, rd);    chk_eq("def_accepted", rd, 32'd0);
        bus_read(A_LATE, rd);   chk_eq("def_late", rd, 32'd0);
        bus_read(A_CLR, rd);    chk_eq("read_clr_zero", rd, 32'd0);
        bus_read(32'h28, rd);   chk_eq("unmapped_zero", rd, 32'd0);
        bus_write(A_DELAY, 32'hFFFF_FFFF);
        bus_read(A_DELAY, rd);  chk_eq("delay_msb_mask", rd, 32'h7FFF_FFFF);

        // Single request: high from k+12 for 5 cycles, on time.
        begin_scn(10, 5, 0);
        do_req(1'b1);
        do_req(1'b0);
        wait_idle(200);
        if (obs_start.size() > 0) begin
            chk_eq("single_start", obs_start[0], last_k + 12);
            chk_eq("single_len", obs_len[0], 5);
        end
        check_sched("single");

        // Eight requests 3 cycles apart: pulses every 7 cycles, seven late.
        begin_scn(100, 4, 2);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b1);
            do_req(1'b0);
            do_req(1'b0);
        end
        wait_idle(500);
        for (int i = 1; i < obs_start.size(); i++)
            chk_eq($sformatf("train_spacing%0d", i), obs_start[i] - obs_start[i-1], 7);
        bus_read(A_LATE, rd); chk_eq("train_late7", rd, 32'd7);
        bus_read(A_ACC, rd);  chk_eq("train_acc8", rd, 32'd8);
        check_sched("train");

        // Nine requests into an 8-deep queue.
        begin_scn(2000, 3, 0);
        repeat (9) do_req(1'b1);
        do_req(1'b0);
        bus_read(A_STATUS, rd); chk_eq("full_status", rd, 32'h308);
        wait_idle(4000);
        bus_read(A_DROP, rd);   chk_eq("full_dropped1", rd, 32'd1);
        check_sched("overflow");

        // Timestamp wrap.
        begin_scn(1000, 5, 0);
        @(negedge clk);
        force dut.ts_q = 32'hFFFF_FFCE;
        #1;
        release dut.ts_q;
        do_req(1'b1);
        do_req(1'b0);
        wait_idle(2000);
        if (obs_start.size() > 0) chk_eq("wrap_start", obs_start[0], last_k + 1002);
        check_sched("wrap");

        // Flush during a pulse with three entries queued.
        begin_scn(0, 50, 0);
        repeat (4) do_req(1'b1);
        do_req(1'b0);
        bus_read(A_STATUS, rd); chk_eq("pre_flush_status", rd, 32'h603);
        bus_write(A_CTRL, 32'h3);
        chk_eq("flush_trig_low", sort_trig, 0);
        bus_read(A_STATUS, rd); chk_eq("post_flush_status", rd, 32'd0);
        bus_read(A_CTRL, rd);   chk_eq("flush_reads_zero", rd, 32'd1);
        repeat (300) @(negedge clk);
        chk_eq("flush_npulse", obs_start.size(), 1);
        bus_read(A_FIRED, rd);  chk_eq("flush_fired", rd, 32'd1);

        // Reset in the middle of a pulse.
        begin_scn(5, 100, 0);
        do_req(1'b1);
        do_req(1'b0);
        wait_trig(100);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("rst_mid_trig", sort_trig, 0);
        chk_eq("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_en = 1'b1;
        bus_read(A_DELAY, rd);  chk_eq("rst2_delay", rd, 32'd31250);
        bus_read(A_DUR, rd);    chk_eq("rst2_dur", rd, 32'd125000);
        bus_read(A_STATUS, rd); chk_eq("rst2_status", rd, 32'd0);
        bus_read(A_ACC, rd);    chk_eq("rst2_accepted", rd, 32'd0);
        bus_write(A_CTRL, 32'h0);
        obs_start.delete(); obs_len.delete();
        do_req(1'b1);
        do_req(1'b0);
        repeat (50) @(negedge clk);
        chk_eq("dis_busy", busy, 0);
        chk_eq("dis_npulse", obs_start.size(), 0);
        bus_read(A_ACC, rd);    chk_eq("dis_accepted", rd, 32'd0);
        bus_write(A_CTRL, 32'h1);

        // Randomized request trains.
        for (int s = 0; s < 6; s++) begin
            int n;
            begin_scn($urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 3));
            n = $urandom_range(10, 24);
            for (int i = 0; i < n; i++) begin
                do_req(1'b1);
                repeat ($urandom_range(0, 4)) do_req(1'b0);
            end
            do_req(1'b0);
            wait_idle(3000);
            check_sched($sformatf("rnd%0d", s));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
